rns_mod47_reverse_conv: RTL and testbench
=========================================

// Module: rns_mod47_reverse_conv
// PURPOSE
// - Reverse (residue-to-binary) converter for the {47, 2^K} residue pair: turns X mod 47 plus X mod 2^K back into X.
// - Output range is X in [0, 47*2^K - 1].
// - Sits downstream of the combinational mod-47 forward converters in the modular-arithmetic datapath.
// - Closes the loop: binary -> residues -> modular ops -> binary.
// - Uses mixed-radix CRT: X = rb + 2^K * k, where k = ((ra - rb) * INV) mod 47 and INV = (2^K)^-1 mod 47.
// - k is computed by a serial shift-add modular multiplier.
// PARAMETERS
// - MOD_A  47  odd modulus (fixed by the datapath; package constant)
// - WA     6   residue width for MOD_A, ceil(log2(MOD_A))
// - K      6   power-of-two modulus exponent (modulus 2^K = 64)
// - INV    36  (2^K mod MOD_A)^-1 mod MOD_A (17*36 = 612 = 13*47 + 1)
// PORTS
// - clk        in   1      rising-edge clock
// - rst_n      in   1      asynchronous, active-low reset
// - in_valid   in   1      in_ra/in_rb valid
// - in_ready   out  1      block can accept a pair (registered)
// - in_ra      in   WA     X mod MOD_A; legal 0..46
// - in_rb      in   K      X mod 2^K; any value 0..63
// - out_valid  out  1      out_x/out_err valid
// - out_ready  in   1      consumer accepts result
// - out_x      out  WA+K   reconstructed X (12 bits)
// - out_err    out  1      in_ra >= MOD_A was seen; out_x forced to 0
// BEHAVIOUR
// - Reset (async, rst_n low):
//   - state = IDLE; in_ready = 0, out_valid = 0, out_x = 0, out_err = 0, internal registers = 0.
//   - in_ready goes 1 on the first rising edge after rst_n deasserts.
//   - Reset mid-operation aborts the conversion silently; no result is emitted.
// - Handshakes:
//   - Input transfer occurs on an edge where in_valid & in_ready. Output transfer occurs on an edge where out_valid & out_ready.
//   - in_ready = 1 only in IDLE. out_valid = 1 only in OUT.
//   - out_x and out_err hold stable while out_valid & !out_ready.
// - FSM:
//   - IDLE -> REDUCE on input transfer. Capture ra, rb.
//   - REDUCE (1 cycle):
//     - rbm = (rb >= 47) ? rb - 47 : rb.
//     - d = ra - rbm; if negative, add 47.
//     - err = (ra >= 47).
//     - acc = 0, cnt = WA-1. Go to MUL.
//   - MUL (WA = 6 cycles), MSB-first over the bits of d:
//     - acc = 2*acc mod 47 (one conditional subtract).
//     - If d[cnt] is set: acc = acc + INV mod 47 (one conditional subtract).
//     - cnt decrements; after cnt == 0, go to OUT with k = acc.
//   - OUT: out_x = err ? 0 : {k, rb}, i.e. k*2^K + rb. out_err = err.
//     - OUT -> IDLE on output transfer.
// - Latency and throughput:
//   - out_valid is asserted 7 edges after the input-transfer edge.
//   - Back-to-back minimum period is 9 cycles when out_ready is held 1.
//   - in_valid while busy is ignored; it is not captured.
// - Arithmetic: every intermediate stays in [0, 46] after each conditional subtract.
// - Widths: 2*acc + INV < 2^8, so the datapath is 8 bits internally.
// - k <= 46, so out_x <= 46*64 + 63 = 3007.
// - No wrap-around can occur.
// STRUCTURE
// - Package rns_mod47_pkg holds:
//   - localparams MOD_A, WA, K, INV;
//   - the state enum {IDLE, REDUCE, MUL, OUT};
//   - function mod_add_cs(a, b) (add with one conditional subtract of MOD_A).
// - One sub-module, mod47_dbl_add_step: combinational step (acc, bit) -> (2*acc + bit*INV) mod 47.
//   - It is instantiated once and reused each MUL cycle.
// - Top level: FSM, capture registers, cnt, acc, and output registers.
// TESTING
// - X=1000: ra=13, rb=40 -> d=20, k=15; out_x=1000, out_err=0, out_valid 7 edges after accept.
// - X=3007 (max): ra=46, rb=63 -> rbm=16, d=30, k=46; out_x=3007.
// - X=47: ra=0, rb=47 (exercises rbm reduction) -> out_x=47. Also ra=0, rb=0 -> out_x=0.
// - ra=50, rb=5 -> out_err=1, out_x=0, same latency.
// - Backpressure: X=1000 with out_ready=0 for 5 cycles. Required:
//   - out_x stable at 1000, in_ready=0, a second in_valid pulse is not captured;
//   - after release, in_ready rises the next cycle.
// - rst_n pulled low during MUL: all outputs 0 asynchronously, no out_valid afterwards.
//   - Next conversion ra=13, rb=40 -> 1000.
// - Exhaustive sweep: all 3008 X values back-to-back with random out_ready -> out_x == X for each.

Source files
------------

// File: rtl/rns_mod47_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rns_mod47_pkg
//  Description : Shared constants, FSM state type and mod-47 helper for the
//                {47, 2^K} residue-to-binary converter.
//                MOD_A / WA : odd modulus and its residue width
//                K          : exponent of the power-of-two modulus
//                INV        : (2^K)^-1 mod MOD_A, used to recover the upper digit
//  Revision    : 1.0  initial release
// ============================================================================
package rns_mod47_pkg;

    localparam int MOD_A = 47;
    localparam int WA    = 6;
    localparam int K     = 6;
    localparam int INV   = 36;          // 17 * 36 = 612 = 13*47 + 1, and 64 mod 47 = 17
    localparam int DW    = 8;           // 2*46 + 36 = 128 still fits in 8 bits
    localparam int XW    = WA + K;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        MUL    = 2'd2,
        OUT    = 2'd3
    } state_e;

    // Sum of two values already in [0, MOD_A-1]; one subtract restores range.
    function automatic logic [DW-1:0] mod_add_cs(input logic [DW-1:0] a,
                                                 input logic [DW-1:0] b);
        logic [DW-1:0] s;
        s = a + b;
        if (s >= DW'(MOD_A))
            s = s - DW'(MOD_A);
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rns_mod47_reverse_conv_if.sv
`default_nettype none
// ============================================================================
//  Module      : rns_mod47_reverse_conv_if
//  Description : Input and output valid/ready channels of the converter.
//                in_valid/in_ready/in_ra/in_rb   : residue pair in
//                out_valid/out_ready/out_x/out_err : reconstructed value out
//                slave  = converter side, master = producer/consumer side
//  Revision    : 1.0  initial release
// ============================================================================
interface rns_mod47_reverse_conv_if
    import rns_mod47_pkg::*;
    ();

    logic          in_valid;
    logic          in_ready;
    logic [WA-1:0] in_ra;
    logic [K-1:0]  in_rb;
    logic          out_valid;
    logic          out_ready;
    logic [XW-1:0] out_x;
    logic          out_err;

    modport slave (
        input  in_valid, in_ra, in_rb, out_ready,
        output in_ready, out_valid, out_x, out_err
    );

    modport master (
        output in_valid, in_ra, in_rb, out_ready,
        input  in_ready, out_valid, out_x, out_err
    );

endinterface
`default_nettype wire

// File: rtl/mod47_dbl_add_step.sv
`default_nettype none
// ============================================================================
//  Module      : mod47_dbl_add_step
//  Description : One MSB-first shift-add step of a mod-47 multiply by INV:
//                o_acc = (2*i_acc + i_bit*INV) mod 47.
//                i_acc : running product, in [0, 46]
//                i_bit : current multiplier bit
//                o_acc : updated product, in [0, 46]
//  Revision    : 1.0  initial release
// ============================================================================
module mod47_dbl_add_step
    import rns_mod47_pkg::*;
(
    input  logic [WA-1:0] i_acc,
    input  logic          i_bit,
    output logic [WA-1:0] o_acc
);

    logic [DW-1:0] w_acc_ext;
    logic [DW-1:0] w_dbl;
    logic [DW-1:0] w_add;

    assign w_acc_ext = DW'(i_acc);
    assign w_dbl     = mod_add_cs(w_acc_ext, w_acc_ext);
    assign w_add     = mod_add_cs(w_dbl, DW'(INV));
    assign o_acc     = i_bit ? w_add[WA-1:0] : w_dbl[WA-1:0];

endmodule
`default_nettype wire

// File: rtl/rns_mod47_reverse_conv.sv
`default_nettype none
// ============================================================================
//  Module      : rns_mod47_reverse_conv
//  Description : Residue-to-binary converter for the {47, 64} pair using
//                mixed-radix CRT: X = rb + 64 * (((ra - rb) * INV) mod 47).
//                The mod-47 product is formed serially, one bit per cycle.
//                clk   : rising-edge clock
//                rst_n : asynchronous active-low reset
//                bus   : input pair channel and result channel (slave side)
//  Revision    : 1.0  initial release
// ============================================================================
module rns_mod47_reverse_conv
    import rns_mod47_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    rns_mod47_reverse_conv_if.slave     bus
);

    state_e        r_state;
    logic [WA-1:0] r_ra;
    logic [K-1:0]  r_rb;
    logic [WA-1:0] r_d;
    logic [WA-1:0] r_acc;
    logic [2:0]    r_cnt;
    logic          r_err;
    logic          r_in_ready;
    logic          r_out_valid;
    logic [XW-1:0] r_out_x;
    logic          r_out_err;

    state_e        w_state_nxt;
    logic          w_in_fire;
    logic          w_out_fire;
    logic [K-1:0]  w_rbm;
    logic [WA:0]   w_diff;
    logic [WA-1:0] w_d;
    logic [WA-1:0] w_step_acc;

    assign w_in_fire  = bus.in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & bus.out_ready;

    // rb < 64 < 2*47, so a single subtract gives rb mod 47.
    assign w_rbm  = (r_rb >= K'(MOD_A)) ? r_rb - K'(MOD_A) : r_rb;
    // Extra MSB of the difference acts as the borrow flag.
    assign w_diff = {1'b0, r_ra} - {1'b0, w_rbm};
    assign w_d    = w_diff[WA] ? WA'(w_diff + (WA+1)'(MOD_A)) : w_diff[WA-1:0];

    mod47_dbl_add_step u_step (
        .i_acc (r_acc),
        .i_bit (r_d[r_cnt]),
        .o_acc (w_step_acc)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_in_fire)      w_state_nxt = REDUCE;
            REDUCE:                      w_state_nxt = MUL;
            MUL:     if (r_cnt == 3'd0)  w_state_nxt = OUT;
            OUT:     if (w_out_fire)     w_state_nxt = IDLE;
            default:                     w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ra        <= '0;
            r_rb        <= '0;
            r_d         <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_x     <= '0;
            r_out_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            // Handshake flags track the next state so they are true registers.
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == OUT);

            case (r_state)
                IDLE: begin
                    if (w_in_fire) begin
                        r_ra <= bus.in_ra;
                        r_rb <= bus.in_rb;
                    end
                end
                REDUCE: begin
                    r_d   <= w_d;
                    r_err <= (r_ra >= WA'(MOD_A));
                    r_acc <= '0;
                    r_cnt <= 3'(WA-1);
                end
                MUL: begin
                    r_acc <= w_step_acc;
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd0) begin
                        // Final step result is the upper mixed-radix digit k.
                        r_out_x   <= r_err ? '0 : {w_step_acc, r_rb};
                        r_out_err <= r_err;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_x     = r_out_x;
    assign bus.out_err   = r_out_err;

endmodule
`default_nettype wire

// File: tb/tb_rns_mod47_reverse_conv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rns_mod47_reverse_conv
//  Description : Self-checking bench for rns_mod47_reverse_conv. Expected
//                results come from a CRT search over X = rb + 64*j.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rns_mod47_reverse_conv;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    rns_mod47_reverse_conv_if bus ();

    rns_mod47_reverse_conv dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: the unique X in [0, 3007] with X%47==ra and X%64==rb.
    function automatic void ref_conv(input int ra, input int rb, output int x, output int err);
        if (ra >= 47) begin
            x = 0; err = 1;
        end else begin
            err = 0; x = -1;
            for (int j = 0; j < 47; j++)
                if ((rb + 64 * j) % 47 == ra) x = rb + 64 * j;
        end
    endfunction

    // Returns positioned 1 time unit after the input-transfer edge.
    task automatic send(input int ra, input int rb);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("in_ready_wait", 32'(bus.in_ready), 32'd1);
        bus.in_ra    = 6'(ra);
        bus.in_rb    = 6'(rb);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        int n;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 30) begin
            @(posedge clk); #1; n++;
        end
        lat = n;
        check("out_valid_wait", 32'(bus.out_valid), 32'd1);
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic directed(input string tag, input int ra, input int rb);
        int x, err, lat;
        ref_conv(ra, rb, x, err);
        send(ra, rb);
        wait_out(lat);
        check({tag, "_latency"}, 32'(lat), 32'd7);
        check({tag, "_x"},       32'(bus.out_x), 32'(x));
        check({tag, "_err"},     32'(bus.out_err), 32'(err));
        take();
        check({tag, "_drop"},    32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        int x, err, lat, n;
        bit done;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_ra     = '0;
        bus.in_rb     = '0;
        bus.out_ready = 1'b0;

        // Reset state
        #2;
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_x",     32'(bus.out_x),     32'd0);
        check("rst_out_err",   32'(bus.out_err),   32'd0);
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b1;
        check("post_rst_in_ready_low", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        check("post_rst_in_ready_high", 32'(bus.in_ready), 32'd1);

        // Directed vectors, including the spec's literal results
        send(13, 40);
        wait_out(lat);
        check("x1000_latency", 32'(lat), 32'd7);
        check("x1000_x", 32'(bus.out_x), 32'd1000);
        check("x1000_err", 32'(bus.out_err), 32'd0);
        take();
        send(46, 63);
        wait_out(lat);
        check("x3007_x", 32'(bus.out_x), 32'd3007);
        take();
        directed("x47", 0, 47);
        directed("x0", 0, 0);
        directed("bad_ra", 50, 5);
        directed("bad_ra63", 63, 63);

        // Backpressure with a stray input pulse while busy
        send(13, 40);
        wait_out(lat);
        for (int i = 0; i < 5; i++) begin
            check("bp_x_stable", 32'(bus.out_x), 32'd1000);
            check("bp_valid",    32'(bus.out_valid), 32'd1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            bus.in_valid = (i == 2);
            bus.in_ra    = 6'd0;
            bus.in_rb    = 6'd1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        take();
        check("bp_in_ready_after", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_no_ghost", 32'(bus.out_valid), 32'd0);
        end

        // Asynchronous reset during MUL; out_x still holds 1000 beforehand
        send(13, 40);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_x",     32'(bus.out_x),     32'd0);
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_in_ready",  32'(bus.in_ready),  32'd0);
        check("arst_out_err",   32'(bus.out_err),   32'd0);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            check("arst_no_result", 32'(bus.out_valid), 32'd0);
        end
        directed("after_rst", 13, 40);

        // Random pairs, including illegal ra
        for (int i = 0; i < 40; i++) begin
            directed("rand", int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
        end

        // Exhaustive sweep with random consumer stalls
        for (int xv = 0; xv < 3008; xv++) begin
            send(xv % 47, xv % 64);
            done = 1'b0;
            n = 0;
            while (!done && n < 60) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                if (bus.out_valid === 1'b1 && bus.out_ready) begin
                    check("sweep_x",   32'(bus.out_x),   32'(xv));
                    check("sweep_err", 32'(bus.out_err), 32'd0);
                    done = 1'b1;
                end
                @(posedge clk); #1;
                n++;
            end
            bus.out_ready = 1'b0;
            if (!done) check("sweep_timeout", 32'(done), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
